// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one full adder stepped LSB-first across WIDTH bits.
// Operands arrive on a valid/ready handshake, the result leaves on another one.

// Single-bit full adder used as the only arithmetic element of the sequencer.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Data_in_valid,
  output logic             Data_in_ready,
  input  logic [WIDTH-1:0] Data_in_A,
  input  logic [WIDTH-1:0] Data_in_B,
  input  logic             Data_in_C,
  output logic             Data_out_valid,
  input  logic             Data_out_ready,
  output logic [WIDTH-1:0] Data_out_Sum,
  output logic             Data_out_Carry,
  output logic             Busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_carry_q;
  logic             in_rdy_q, out_vld_q, busy_q;

  logic             fa_s, fa_co;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum_d;

  full_adder u_fa (
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .c_i  (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  // New sum bit enters at the MSB; the widened vector keeps WIDTH=1 legal.
  always_comb begin
    sum_ext = {fa_s, sum_q};
    sum_d   = sum_ext[WIDTH:1];
  end

  // Sequencer FSM and datapath; result is latched into separate output
  // registers so it stays visible through the next IDLE/RUN.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
      in_rdy_q    <= 1'b1;
      out_vld_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Data_in_valid && in_rdy_q) begin
            a_q      <= Data_in_A;
            b_q      <= Data_in_B;
            sum_q    <= '0;
            carry_q  <= Data_in_C;
            cnt_q    <= '0;
            in_rdy_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= sum_d;
          carry_q <= fa_co;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            out_sum_q   <= sum_d;
            out_carry_q <= fa_co;
            out_vld_q   <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (Data_out_ready) begin
            out_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            in_rdy_q  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          in_rdy_q  <= 1'b1;
          out_vld_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign Data_in_ready  = in_rdy_q;
  assign Data_out_valid = out_vld_q;
  assign Data_out_Sum   = out_sum_q;
  assign Data_out_Carry = out_carry_q;
  assign Busy           = busy_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 instance for directed + random ops with
// backpressure, WIDTH=1 instance for the tied-high throughput case.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst8, iv8, ir8, ov8, or8, c8, co8, busy8;
  logic [W-1:0] a8, b8, s8;
  logic         rst1, iv1, ir1, ov1, or1, c1, co1, busy1;
  logic [0:0]   a1, b1, s1;

  int n_cmp = 0;
  int n_err = 0;

  serial_add_ctrl #(.WIDTH(W)) u8 (
    .Clk(clk), .Reset(rst8), .Data_in_valid(iv8), .Data_in_ready(ir8),
    .Data_in_A(a8), .Data_in_B(b8), .Data_in_C(c8),
    .Data_out_valid(ov8), .Data_out_ready(or8),
    .Data_out_Sum(s8), .Data_out_Carry(co8), .Busy(busy8)
  );

  serial_add_ctrl #(.WIDTH(1)) u1 (
    .Clk(clk), .Reset(rst1), .Data_in_valid(iv1), .Data_in_ready(ir1),
    .Data_in_A(a1), .Data_in_B(b1), .Data_in_C(c1),
    .Data_out_valid(ov1), .Data_out_ready(or1),
    .Data_out_Sum(s1), .Data_out_Carry(co1), .Busy(busy1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=8 operation: accept, check latency/result, hold in DONE, drain.
  task automatic op8(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                     input int hold);
    logic [W:0] exp;
    int k;
    exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    @(negedge clk);
    a8 = a; b8 = b; c8 = c; iv8 = 1'b1;
    k = 0;
    while (!ir8 && k < 20) begin @(negedge clk); k++; end
    chk("accept_ready", 64'(ir8), 64'(1));
    if (!ir8) begin iv8 = 1'b0; return; end
    @(negedge clk);
    iv8 = 1'b0; a8 = W'($urandom); b8 = W'($urandom); c8 = 1'($urandom);
    chk("run_busy", 64'(busy8), 64'(1));
    chk("run_in_ready", 64'(ir8), 64'(0));
    k = 0;
    while (!ov8 && k < 40) begin
      or8 = 1'($urandom);
      a8 = W'($urandom);
      @(negedge clk);
      k++;
    end
    or8 = 1'b0;
    chk("latency", 64'(k), 64'(W));
    chk("sum", 64'(s8), 64'(exp[W-1:0]));
    chk("carry", 64'(co8), 64'(exp[W]));
    for (int h = 0; h < hold; h++) begin
      iv8 = (h % 2 == 0);
      a8 = W'($urandom);
      @(negedge clk);
      chk("hold_valid", 64'(ov8), 64'(1));
      chk("hold_sum", 64'(s8), 64'(exp[W-1:0]));
      chk("hold_carry", 64'(co8), 64'(exp[W]));
      chk("hold_in_ready", 64'(ir8), 64'(0));
    end
    iv8 = 1'b0; or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0;
    chk("idle_valid", 64'(ov8), 64'(0));
    chk("idle_in_ready", 64'(ir8), 64'(1));
    chk("idle_busy", 64'(busy8), 64'(0));
    chk("idle_sum_kept", 64'(s8), 64'(exp[W-1:0]));
  endtask

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int last, nv, first;
    rst8 = 1'b1; iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
    rst1 = 1'b1; iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0;
    repeat (2) @(negedge clk);
    rst8 = 1'b0;
    chk("rst_in_ready", 64'(ir8), 64'(1));
    chk("rst_valid", 64'(ov8), 64'(0));
    chk("rst_sum", 64'(s8), 64'(0));
    chk("rst_carry", 64'(co8), 64'(0));
    chk("rst_busy", 64'(busy8), 64'(0));

    // Directed vectors
    op8(8'h5A, 8'h3C, 1'b0, 0);
    op8(8'hFF, 8'h01, 1'b0, 1);
    op8(8'hFF, 8'hFF, 1'b1, 0);
    op8(8'h5A, 8'h3C, 1'b0, 5);

    // Reset during the 4th RUN cycle abandons the operation
    @(negedge clk);
    a8 = 8'hC3; b8 = 8'h77; c8 = 1'b1; iv8 = 1'b1;
    @(negedge clk);
    iv8 = 1'b0;
    repeat (3) @(negedge clk);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    chk("midrst_in_ready", 64'(ir8), 64'(1));
    chk("midrst_valid", 64'(ov8), 64'(0));
    chk("midrst_sum", 64'(s8), 64'(0));
    chk("midrst_carry", 64'(co8), 64'(0));
    chk("midrst_busy", 64'(busy8), 64'(0));
    repeat (12) begin
      @(negedge clk);
      chk("midrst_no_result", 64'(ov8), 64'(0));
    end
    op8(8'h10, 8'h20, 1'b0, 0);

    // Random operands with random backpressure
    for (int i = 0; i < 1000; i++)
      op8(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    // WIDTH=1 with valid/ready tied high: one result every 3 cycles
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; iv1 = 1'b1; or1 = 1'b1; rst1 = 1'b0;
    last = -1; nv = 0; first = -1;
    for (int cyc = 0; cyc < 36; cyc++) begin
      @(negedge clk);
      if (ov1) begin
        chk("w1_sum", 64'(s1), 64'(1));
        chk("w1_carry", 64'(co1), 64'(1));
        if (last >= 0) chk("w1_period", 64'(cyc - last), 64'(3));
        else first = cyc;
        last = cyc;
        nv++;
      end
    end
    chk("w1_first_latency", 64'(first), 64'(1));
    chk("w1_op_count", 64'(nv), 64'(12));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
